rptr_burst_ctrl: RTL and testbench

//  Read-side pointer controller for the async FIFO with single-word pops plus a burst-read engine.

---
 rtl/async_fifo_pkg.sv | 31 +++
 rtl/gray2bin.sv | 22 ++
 rtl/rptr_burst_ctrl.sv | 126 ++++++++++++
 tb/tb_rptr_burst_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// ============================================================================
// Module   : async_fifo_pkg
// Brief    : Gray/binary pointer helpers and read-side FSM states for the async FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

package async_fifo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

  // Width-generic up to 32 bits; callers cast the result down to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray2bin.sv
// ============================================================================
// Module   : gray2bin
// Brief    : Combinational gray-to-binary converter built as an xor-prefix chain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gray2bin #(
  parameter int W = 9
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  // Each binary bit is the parity of all gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/rptr_burst_ctrl.sv
// ============================================================================
// Module   : rptr_burst_ctrl
// Brief    : Async FIFO read-pointer controller with single pops and a burst-read engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rptr_burst_ctrl
  import async_fifo_pkg::*;
#(
  parameter  int ADDR_LEN  = 8,
  parameter  int MAX_BURST = 16,
  parameter  int AE_THRESH = 4,
  localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rincr_i,
  input  logic                rburst_req_i,
  input  logic [LEN_W-1:0]    rburst_len_i,
  input  logic [ADDR_LEN:0]   w2rptr_sync_i,
  output logic [ADDR_LEN-1:0] fifo_raddr_o,
  output logic                rd_en_o,
  output logic [ADDR_LEN:0]   rptr_o,
  output logic                rempty_o,
  output logic                ralmost_empty_o,
  output logic [ADDR_LEN:0]   rlevel_o,
  output logic                rburst_busy_o,
  output logic                rburst_ack_o,
  output logic                rerr_o
);

  localparam int               PW          = ADDR_LEN + 1;
  localparam logic [LEN_W-1:0] C_MAX_LEN   = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0] C_LEN_ONE   = LEN_W'(1);
  localparam logic [PW-1:0]    C_AE_THRESH = PW'(AE_THRESH);

  rd_state_e        r_state, w_state_nxt;
  logic [LEN_W-1:0] r_remaining, w_remaining_nxt;
  logic [PW-1:0]    r_rbin, w_rbin_nxt;
  logic [PW-1:0]    r_rptr, r_rlevel;
  logic             r_rempty, r_ralmost_empty;
  logic [PW-1:0]    w_wbin, w_level_nxt, w_rgray_nxt;
  logic             w_adv, w_ack, w_err;

  gray2bin #(
    .W (PW)
  ) u_wptr_g2b (
    .i_gray (w2rptr_sync_i),
    .o_bin  (w_wbin)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_adv           = 1'b0;
    w_ack           = 1'b0;
    w_err           = 1'b0;
    case (r_state)
      BURST: begin
        w_adv           = 1'b1;
        w_remaining_nxt = r_remaining - C_LEN_ONE;
        if (r_remaining == C_LEN_ONE) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        if (rburst_req_i && (rburst_len_i == '0 || rburst_len_i > C_MAX_LEN)) begin
          w_ack = 1'b1;
          w_err = 1'b1;
        end else if (rburst_req_i && (PW'(rburst_len_i) <= r_rlevel)) begin
          // Accepting a burst pops its first word now; single pops are dropped this cycle.
          w_ack           = 1'b1;
          w_adv           = 1'b1;
          w_remaining_nxt = rburst_len_i - C_LEN_ONE;
          if (rburst_len_i != C_LEN_ONE) begin
            w_state_nxt = BURST;
          end
        end else if (rincr_i) begin
          if (r_rempty) begin
            w_err = 1'b1;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
    endcase
  end

  assign w_rbin_nxt  = r_rbin + PW'(w_adv);
  assign w_rgray_nxt = PW'(bin2gray(32'(w_rbin_nxt)));
  assign w_level_nxt = w_wbin - w_rbin_nxt;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state         <= IDLE;
      r_remaining     <= '0;
      r_rbin          <= '0;
      r_rptr          <= '0;
      r_rlevel        <= '0;
      r_rempty        <= 1'b1;
      r_ralmost_empty <= 1'b1;
    end else begin
      r_state         <= w_state_nxt;
      r_remaining     <= w_remaining_nxt;
      r_rbin          <= w_rbin_nxt;
      r_rptr          <= w_rgray_nxt;
      r_rlevel        <= w_level_nxt;
      r_rempty        <= (w_rgray_nxt == w2rptr_sync_i);
      r_ralmost_empty <= (w_level_nxt <= C_AE_THRESH);
    end
  end

  assign fifo_raddr_o    = r_rbin[ADDR_LEN-1:0];
  assign rd_en_o         = w_adv;
  assign rptr_o          = r_rptr;
  assign rempty_o        = r_rempty;
  assign ralmost_empty_o = r_ralmost_empty;
  assign rlevel_o        = r_rlevel;
  assign rburst_busy_o   = (r_state == BURST);
  assign rburst_ack_o    = w_ack;
  assign rerr_o          = w_err;

endmodule

`default_nettype wire

// File: tb/tb_rptr_burst_ctrl.sv
// ============================================================================
// Module   : tb_rptr_burst_ctrl
// Brief    : Randomised and directed bench for rptr_burst_ctrl (default and 3-bit address builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rptr_burst_ctrl;

  logic rclk = 1'b0;
  logic rrst = 1'b1;
  always #5 rclk = ~rclk;

  // Index 0: ADDR_LEN=8/MAX_BURST=16/AE=4, index 1: ADDR_LEN=3/MAX_BURST=4/AE=2
  logic       incr [2];
  logic       req  [2];
  logic [4:0] blen [2];
  logic [8:0] wptr [2];

  logic       a_incr, a_req, a_rden, a_empty, a_ae, a_busy, a_ack, a_err;
  logic [4:0] a_len;
  logic [8:0] a_wptr, a_rptr, a_level;
  logic [7:0] a_raddr;
  logic       b_incr, b_req, b_rden, b_empty, b_ae, b_busy, b_ack, b_err;
  logic [2:0] b_len, b_raddr;
  logic [3:0] b_wptr, b_rptr, b_level;

  assign a_incr = incr[0];
  assign a_req  = req[0];
  assign a_len  = blen[0];
  assign a_wptr = wptr[0];
  assign b_incr = incr[1];
  assign b_req  = req[1];
  assign b_len  = blen[1][2:0];
  assign b_wptr = wptr[1][3:0];

  rptr_burst_ctrl #(.ADDR_LEN(8), .MAX_BURST(16), .AE_THRESH(4)) dut_a (
    .rclk(rclk), .rrst(rrst), .rincr_i(a_incr), .rburst_req_i(a_req), .rburst_len_i(a_len),
    .w2rptr_sync_i(a_wptr), .fifo_raddr_o(a_raddr), .rd_en_o(a_rden), .rptr_o(a_rptr),
    .rempty_o(a_empty), .ralmost_empty_o(a_ae), .rlevel_o(a_level), .rburst_busy_o(a_busy),
    .rburst_ack_o(a_ack), .rerr_o(a_err)
  );

  rptr_burst_ctrl #(.ADDR_LEN(3), .MAX_BURST(4), .AE_THRESH(2)) dut_b (
    .rclk(rclk), .rrst(rrst), .rincr_i(b_incr), .rburst_req_i(b_req), .rburst_len_i(b_len),
    .w2rptr_sync_i(b_wptr), .fifo_raddr_o(b_raddr), .rd_en_o(b_rden), .rptr_o(b_rptr),
    .rempty_o(b_empty), .ralmost_empty_o(b_ae), .rlevel_o(b_level), .rburst_busy_o(b_busy),
    .rburst_ack_o(b_ack), .rerr_o(b_err)
  );

  // {raddr, rd_en, rptr, empty, almost_empty, level, busy, ack, err}, fields zero-extended to 9 bits
  logic [32:0] obs [2];
  assign obs[0] = {1'b0, a_raddr, a_rden, a_rptr, a_empty, a_ae, a_level, a_busy, a_ack, a_err};
  assign obs[1] = {6'b0, b_raddr, b_rden, 5'b0, b_rptr, b_empty, b_ae, 5'b0, b_level,
                   b_busy, b_ack, b_err};

  // Reference model: pop count, write count and words still owed by an accepted burst
  int          pw [2];
  int          maxb [2];
  int          aeth [2];
  int          m_rd [2];
  int          m_w [2];
  int          m_left [2];
  int          m_lvl [2];
  int          m_rptr [2];
  bit          m_empty [2];
  bit          m_ae [2];
  int          nx_rd [2];
  int          nx_left [2];
  bit          nx_rst;
  logic [32:0] exp_v [2];
  int          n_checks = 0;
  int          n_fails  = 0;

  function automatic int msk(input int u);
    return (1 << pw[u]) - 1;
  endfunction

  task automatic set_w(input int u, input int cnt);
    int g;
    m_w[u]  = cnt;
    g       = cnt & msk(u);
    wptr[u] = 9'(g ^ (g >> 1));
  endtask

  task automatic predict();
    for (int u = 0; u < 2; u++) begin
      bit adv, ack, err, acc;
      int l;
      adv = 1'b0; ack = 1'b0; err = 1'b0; acc = 1'b0;
      nx_left[u] = m_left[u];
      l = int'(blen[u]);
      if (m_left[u] > 0) begin
        adv        = 1'b1;
        nx_left[u] = m_left[u] - 1;
      end else begin
        if (req[u]) begin
          if (l == 0 || l > maxb[u]) begin
            ack = 1'b1; err = 1'b1; acc = 1'b1;
          end else if (l <= m_lvl[u]) begin
            ack = 1'b1; adv = 1'b1; acc = 1'b1;
            nx_left[u] = l - 1;
          end
        end
        if (!acc && incr[u]) begin
          if (m_empty[u]) err = 1'b1;
          else            adv = 1'b1;
        end
      end
      nx_rd[u] = (m_rd[u] + int'(adv)) & msk(u);
      exp_v[u] = {9'(m_rd[u] & (msk(u) >> 1)), adv, 9'(m_rptr[u]), m_empty[u], m_ae[u],
                  9'(m_lvl[u]), (m_left[u] > 0), ack, err};
    end
    nx_rst = rrst;
  endtask

  task automatic advance();
    for (int u = 0; u < 2; u++) begin
      if (nx_rst) begin
        m_rd[u] = 0; m_left[u] = 0; m_lvl[u] = 0; m_rptr[u] = 0;
        m_empty[u] = 1'b1; m_ae[u] = 1'b1;
      end else begin
        m_rd[u]    = nx_rd[u];
        m_left[u]  = nx_left[u];
        m_lvl[u]   = (m_w[u] - m_rd[u]) & msk(u);
        m_empty[u] = (m_lvl[u] == 0);
        m_ae[u]    = (m_lvl[u] <= aeth[u]);
        m_rptr[u]  = m_rd[u] ^ (m_rd[u] >> 1);
      end
    end
  endtask

  task automatic settle();
    #1;
    predict();
  endtask

  task automatic step();
    @(posedge rclk);
    advance();
    #1;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      incr[u] = 1'b0; req[u] = 1'b0; blen[u] = '0;
      set_w(u, 0);
    end
    settle(); step();
    settle(); step();
    rrst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    for (int u = 0; u < 2; u++) begin
      n_checks++;
      if (obs[u] !== exp_v[u]) begin
        n_fails++; $display("FAIL reset_model u%0d: got %h want %h", u, obs[u], exp_v[u]);
      end
    end
    n_checks++;
    if (a_empty !== 1'b1 || a_level !== 9'd0 || a_rptr !== 9'd0 || a_ae !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_flags: empty=%b level=%0d rptr=%h ae=%b want 1/0/0/1",
               a_empty, a_level, a_rptr, a_ae);
    end
    step();
  endtask

  task automatic test_single_pops();
    do_reset();
    set_w(0, 5);
    settle(); step();
    for (int i = 0; i < 6; i++) begin
      incr[0] = 1'b1;
      settle();
      n_checks++;
      if (obs[0] !== exp_v[0]) begin
        n_fails++; $display("FAIL pop_model i=%0d: got %h want %h", i, obs[0], exp_v[0]);
      end
      n_checks++;
      if (i < 5 && (a_rden !== 1'b1 || a_raddr !== 8'(i))) begin
        n_fails++; $display("FAIL pop_addr i=%0d: rd_en=%b raddr=%0d want 1/%0d", i, a_rden, a_raddr, i);
      end else if (i == 5 && (a_err !== 1'b1 || a_rden !== 1'b0 || a_raddr !== 8'd5 || a_empty !== 1'b1)) begin
        n_fails++;
        $display("FAIL pop_underflow: err=%b rd_en=%b raddr=%0d empty=%b want 1/0/5/1",
                 a_err, a_rden, a_raddr, a_empty);
      end
      step();
    end
    incr[0] = 1'b0;
  endtask

  task automatic test_burst();
    do_reset();
    set_w(0, 10);
    settle(); step();
    req[0] = 1'b1; blen[0] = 5'd8;
    for (int i = 0; i < 8; i++) begin
      settle();
      n_checks++;
      if (obs[0] !== exp_v[0]) begin
        n_fails++; $display("FAIL burst_model i=%0d: got %h want %h", i, obs[0], exp_v[0]);
      end
      n_checks++;
      if (a_rden !== 1'b1 || a_raddr !== 8'(i) || a_ack !== (i == 0)) begin
        n_fails++; $display("FAIL burst_word i=%0d: rd_en=%b raddr=%0d ack=%b", i, a_rden, a_raddr, a_ack);
      end
      step();
      req[0] = 1'b0;
    end
    settle();
    n_checks++;
    if (a_level !== 9'd2 || a_ae !== 1'b1 || a_busy !== 1'b0 || a_rden !== 1'b0) begin
      n_fails++;
      $display("FAIL burst_end: level=%0d ae=%b busy=%b rd_en=%b want 2/1/0/0", a_level, a_ae, a_busy, a_rden);
    end
    step();
  endtask

  task automatic test_wait_illegal();
    bit got;
    got = 1'b0;
    do_reset();
    set_w(0, 3);
    settle(); step();
    req[0] = 1'b1; blen[0] = 5'd6;
    for (int k = 0; k < 12 && !got; k++) begin
      if (k >= 2 && m_w[0] < 6) set_w(0, m_w[0] + 1);
      settle();
      n_checks++;
      if (obs[0] !== exp_v[0]) begin
        n_fails++; $display("FAIL wait_model k=%0d: got %h want %h", k, obs[0], exp_v[0]);
      end
      if (a_ack === 1'b1) begin
        got = 1'b1;
        n_checks++;
        if (a_level !== 9'd6) begin
          n_fails++; $display("FAIL wait_ack_level: level=%0d want 6", a_level);
        end
      end
      step();
      if (got) req[0] = 1'b0;
    end
    n_checks++;
    if (!got) begin
      n_fails++; $display("FAIL wait_ack_timeout: ack never seen, want ack once level reaches 6");
    end
    req[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      n_checks++;
      if (obs[0] !== exp_v[0]) begin
        n_fails++; $display("FAIL wait_drain k=%0d: got %h want %h", k, obs[0], exp_v[0]);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      req[0]  = 1'b1;
      blen[0] = (k == 0) ? 5'd0 : 5'd17;
      settle();
      n_checks++;
      if (a_ack !== 1'b1 || a_err !== 1'b1 || a_rden !== 1'b0 || obs[0] !== exp_v[0]) begin
        n_fails++;
        $display("FAIL illegal_len len=%0d: ack=%b err=%b rd_en=%b want 1/1/0", blen[0], a_ack, a_err, a_rden);
      end
      step();
    end
    req[0] = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    int         wcnt [3];
    int         npop [3];
    wcnt = '{8, 14, 18};
    npop = '{8, 6, 4};
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      incr[1] = 1'b0;
      set_w(1, wcnt[ph]);
      settle(); step();
      for (int i = 0; i < npop[ph]; i++) begin
        incr[1] = 1'b1;
        settle();
        n_checks++;
        if (obs[1] !== exp_v[1]) begin
          n_fails++; $display("FAIL wrap_model ph=%0d i=%0d: got %h want %h", ph, i, obs[1], exp_v[1]);
        end
        prev = b_rptr;
        step();
        if (ph == 2) begin
          n_checks++;
          if ($countones(b_rptr ^ prev) != 1 || b_raddr !== 3'((14 + i + 1) & 7)) begin
            n_fails++;
            $display("FAIL wrap_step i=%0d: rptr %h->%h raddr=%0d", i, prev, b_rptr, b_raddr);
          end
        end
      end
    end
    incr[1] = 1'b0;
    settle();
    n_checks++;
    if (b_level !== 4'd0 || b_empty !== 1'b1 || obs[1] !== exp_v[1]) begin
      n_fails++; $display("FAIL wrap_end: level=%0d empty=%b want 0/1", b_level, b_empty);
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_w(0, 20);
    settle(); step();
    req[0] = 1'b1; blen[0] = 5'd8;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) rrst = 1'b1;
      settle();
      if (c < 3) begin
        n_checks++;
        if (obs[0] !== exp_v[0]) begin
          n_fails++; $display("FAIL midrst_model c=%0d: got %h want %h", c, obs[0], exp_v[0]);
        end
      end
      step();
      req[0] = 1'b0;
    end
    rrst = 1'b0;
    settle();
    n_checks++;
    if (a_rden !== 1'b0 || a_busy !== 1'b0 || a_empty !== 1'b1 || a_ae !== 1'b1 ||
        a_level !== 9'd0 || a_rptr !== 9'd0 || a_raddr !== 8'd0 || a_ack !== 1'b0 || a_err !== 1'b0) begin
      n_fails++; $display("FAIL midrst_state: got %h want reset values", obs[0]);
    end
    step();
    settle();
    n_checks++;
    if (obs[0] !== exp_v[0]) begin
      n_fails++; $display("FAIL midrst_after: got %h want %h", obs[0], exp_v[0]);
    end
    step();
  endtask

  task automatic test_random();
    bit ack_seen [2];
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int u = 0; u < 2; u++) begin
        if ($urandom_range(0, 2) == 0 && ((m_w[u] - m_rd[u]) & msk(u)) < (1 << (pw[u] - 1)))
          set_w(u, m_w[u] + 1);
        if (!req[u] && $urandom_range(0, 7) == 0) begin
          req[u]  = 1'b1;
          blen[u] = 5'($urandom_range(0, maxb[u] + 1));
        end
        incr[u] = 1'($urandom_range(0, 1));
      end
      settle();
      for (int u = 0; u < 2; u++) begin
        n_checks++;
        if (obs[u] !== exp_v[u]) begin
          n_fails++; $display("FAIL random u%0d n=%0d: got %h want %h", u, n, obs[u], exp_v[u]);
        end
        ack_seen[u] = exp_v[u][1];
      end
      step();
      for (int u = 0; u < 2; u++) if (ack_seen[u]) req[u] = 1'b0;
    end
    for (int u = 0; u < 2; u++) begin
      incr[u] = 1'b0; req[u] = 1'b0;
    end
  endtask

  initial begin
    pw   = '{9, 4};
    maxb = '{16, 4};
    aeth = '{4, 2};
    for (int u = 0; u < 2; u++) begin
      incr[u] = 1'b0; req[u] = 1'b0; blen[u] = '0;
      m_rd[u] = 0; m_left[u] = 0; m_lvl[u] = 0; m_rptr[u] = 0;
      m_empty[u] = 1'b1; m_ae[u] = 1'b1;
      set_w(u, 0);
    end
    @(posedge rclk);
    #1;
    test_reset();
    test_single_pops();
    test_burst();
    test_wait_illegal();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
